// File: rtl/acquisition_controller_pkg.sv
// Shared encodings for the acquisition controller, register bank and readout.
package acquisition_controller_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StWaitTrig,
        StPost,
        StDone
    } acq_state_e;

    localparam logic TrigEdgeRising  = 1'b0;
    localparam logic TrigEdgeFalling = 1'b1;
    localparam logic TrigSourceLevel = 1'b0;
    localparam logic TrigSourceExt   = 1'b1;

endpackage

// File: rtl/acquisition_controller_trigger_detector.sv
// Level/edge or external trigger detection; hit is a single cycle, qualified by sample acceptance.
module acquisition_controller_trigger_detector
    import acquisition_controller_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  sample_valid,
    input  logic                  eval,
    input  logic                  force_hit,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] level,
    input  logic                  trig_edge,
    input  logic                  trig_source,
    input  logic                  ext_trigger,
    output logic                  hit
);

    logic [DATA_WIDTH-1:0] prev_q;
    logic                  prev_valid_q;
    logic                  rise;
    logic                  fall;
    logic                  src_hit;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (clear) begin
            prev_valid_q <= 1'b0;
        end else if (sample_valid) begin
            prev_q       <= data;
            prev_valid_q <= 1'b1;
        end
    end

    always_comb begin
        rise    = prev_valid_q && (prev_q < level) && (data >= level);
        fall    = prev_valid_q && (prev_q > level) && (data <= level);
        src_hit = (trig_source == TrigSourceExt) ? ext_trigger
                : ((trig_edge == TrigEdgeFalling) ? fall : rise);
        hit     = sample_valid && eval && (force_hit || src_hit);
    end

endmodule

// File: rtl/acquisition_controller.sv
// Sequences one capture from the ADC stream into a circular sample RAM:
// pre-trigger fill, trigger detection, post-trigger count.
module acquisition_controller
    import acquisition_controller_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] SI_data,
    input  logic                  SI_rdy,
    output logic                  SI_ack,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  force_trigger,
    input  logic                  trigger_source,
    input  logic                  trigger_edge,
    input  logic [DATA_WIDTH-1:0] trigger_level,
    input  logic                  ext_trigger,
    input  logic [ADDR_WIDTH-1:0] num_samples,
    input  logic [ADDR_WIDTH-1:0] pretrigger,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] trigger_addr,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

    acq_state_e            state_q;
    logic [ADDR_WIDTH-1:0] n_q;
    logic [ADDR_WIDTH-1:0] p_q;
    logic                  src_q;
    logic                  edge_q;
    logic [DATA_WIDTH-1:0] level_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  force_q;

    logic                  capturing;
    logic                  accept;
    logic                  start_ok;
    logic                  trig_hit;
    logic [ADDR_WIDTH-1:0] p_clamped;
    logic [ADDR_WIDTH-1:0] ptr_next;
    logic [ADDR_WIDTH-1:0] post_len;

    // Every sample is consumed so the ADC interface never overruns.
    assign SI_ack = SI_rdy;

    always_comb begin
        capturing = (state_q == StPre) || (state_q == StWaitTrig) || (state_q == StPost);
        accept    = SI_rdy && capturing;
        start_ok  = start && !stop && ((state_q == StIdle) || (state_q == StDone))
                    && (num_samples != '0);
        p_clamped = (pretrigger >= num_samples) ? (num_samples - AddrOne) : pretrigger;
        ptr_next  = (wr_ptr_q == n_q - AddrOne) ? '0 : (wr_ptr_q + AddrOne);
        post_len  = n_q - p_q - AddrOne;
        busy      = capturing;
        done      = (state_q == StDone);
    end

    acquisition_controller_trigger_detector #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_trigger_detector (
        .clk_i       (clk_i),
        .reset       (reset),
        .clear       (start_ok),
        .sample_valid(accept),
        .eval        (state_q == StWaitTrig),
        .force_hit   (force_q || force_trigger),
        .data        (SI_data),
        .level       (level_q),
        .trig_edge   (edge_q),
        .trig_source (src_q),
        .ext_trigger (ext_trigger),
        .hit         (trig_hit)
    );

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            n_q          <= '0;
            p_q          <= '0;
            src_q        <= 1'b0;
            edge_q       <= 1'b0;
            level_q      <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            force_q      <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            mem_we       <= 1'b0;
            trigger_addr <= '0;
        end else begin
            // Write path runs even in the stop cycle so an accepted sample is never lost.
            mem_we <= accept;
            if (accept) begin
                mem_data <= SI_data;
                mem_addr <= wr_ptr_q;
                wr_ptr_q <= ptr_next;
            end

            if (stop) begin
                state_q <= StIdle;
                force_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        force_q <= 1'b0;
                        if (start_ok) begin
                            n_q      <= num_samples;
                            p_q      <= p_clamped;
                            src_q    <= trigger_source;
                            edge_q   <= trigger_edge;
                            level_q  <= trigger_level;
                            wr_ptr_q <= '0;
                            cnt_q    <= '0;
                            state_q  <= (p_clamped == '0) ? StWaitTrig : StPre;
                        end
                    end
                    StPre: begin
                        if (force_trigger) force_q <= 1'b1;
                        if (accept) begin
                            if (cnt_q + AddrOne == p_q) begin
                                cnt_q   <= '0;
                                state_q <= StWaitTrig;
                            end else begin
                                cnt_q <= cnt_q + AddrOne;
                            end
                        end
                    end
                    StWaitTrig: begin
                        if (trig_hit) begin
                            trigger_addr <= wr_ptr_q;
                            force_q      <= 1'b0;
                            cnt_q        <= '0;
                            state_q      <= (post_len == '0) ? StDone : StPost;
                        end else if (force_trigger) begin
                            force_q <= 1'b1;
                        end
                    end
                    StPost: begin
                        if (accept) begin
                            if (cnt_q + AddrOne == post_len) begin
                                state_q <= StDone;
                            end else begin
                                cnt_q <= cnt_q + AddrOne;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acquisition_controller.sv
// Directed bench for acquisition_controller with hand-computed expectations.
module tb_acquisition_controller;

    logic       clk_i = 1'b0;
    logic       reset;
    logic [7:0] SI_data;
    logic       SI_rdy;
    logic       SI_ack;
    logic       start;
    logic       stop;
    logic       force_trigger;
    logic       trigger_source;
    logic       trigger_edge;
    logic [7:0] trigger_level;
    logic       ext_trigger;
    logic [9:0] num_samples;
    logic [9:0] pretrigger;
    logic [9:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;
    logic [9:0] trigger_addr;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    // Write monitor: running write count, last write and a RAM image.
    int         wr_count = 0;
    logic [9:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic [7:0] tb_mem [0:15];
    int         base;

    always #5 clk_i = ~clk_i;

    acquisition_controller #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(10)
    ) dut (
        .clk_i         (clk_i),
        .reset         (reset),
        .SI_data       (SI_data),
        .SI_rdy        (SI_rdy),
        .SI_ack        (SI_ack),
        .start         (start),
        .stop          (stop),
        .force_trigger (force_trigger),
        .trigger_source(trigger_source),
        .trigger_edge  (trigger_edge),
        .trigger_level (trigger_level),
        .ext_trigger   (ext_trigger),
        .num_samples   (num_samples),
        .pretrigger    (pretrigger),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_we        (mem_we),
        .trigger_addr  (trigger_addr),
        .busy          (busy),
        .done          (done)
    );

    always @(negedge clk_i) begin
        if (mem_we) begin
            wr_count = wr_count + 1;
            last_addr = mem_addr;
            last_data = mem_data;
            tb_mem[mem_addr[3:0]] = mem_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic pulse_start(input logic [9:0] n, input logic [9:0] p, input logic src,
                               input logic edg, input logic [7:0] lvl);
        num_samples    = n;
        pretrigger     = p;
        trigger_source = src;
        trigger_edge   = edg;
        trigger_level  = lvl;
        start          = 1'b1;
        step();
        start          = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic ext);
        SI_data     = d;
        ext_trigger = ext;
        SI_rdy      = 1'b1;
        step();
        SI_rdy      = 1'b0;
        ext_trigger = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        SI_data = '0; SI_rdy = 1'b0; start = 1'b0; stop = 1'b0; force_trigger = 1'b0;
        trigger_source = 1'b0; trigger_edge = 1'b0; trigger_level = '0; ext_trigger = 1'b0;
        num_samples = '0; pretrigger = '0;
        idle(2);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_we", mem_we, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_trig_addr", trigger_addr, 0);
        reset = 1'b0;
        idle(1);

        // N=16 P=4 rising at 0x80 on a ramp, one sample every third cycle.
        pulse_start(10'd16, 10'd4, 1'b0, 1'b0, 8'h80);
        check("t1_busy", busy, 1);
        base = wr_count;
        SI_rdy = 1'b1;
        #1 check("t1_ack_hi", SI_ack, 1);
        SI_rdy = 1'b0;
        #1 check("t1_ack_lo", SI_ack, 0);
        for (int k = 0; k < 256 && !done; k++) begin
            send(k[7:0], 1'b0);
            idle(2);
        end
        idle(1);
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_trig_addr", trigger_addr, 0);
        check("t1_writes", wr_count - base, 140);
        check("t1_last_addr", last_addr, 11);
        check("t1_last_data", last_data, 8'h8b);
        check("t1_mem0", tb_mem[0], 8'h80);
        check("t1_mem12", tb_mem[12], 8'h7c);

        // N=8 P=0 falling at 0x40; pointer wraps 7 -> 0.
        pulse_start(10'd8, 10'd0, 1'b0, 1'b1, 8'h40);
        check("t2_done_clr", done, 0);
        base = wr_count;
        send(8'h50, 1'b0);
        check("t2_we", mem_we, 1);
        check("t2_addr0", mem_addr, 0);
        check("t2_data0", mem_data, 8'h50);
        send(8'h40, 1'b0);
        check("t2_trig_addr", trigger_addr, 1);
        for (int i = 0; i < 6; i++) send(8'h40, 1'b0);
        check("t2_not_done", done, 0);
        send(8'h40, 1'b0);
        check("t2_done", done, 1);
        check("t2_wrap_addr", mem_addr, 0);
        idle(2);
        check("t2_writes", wr_count - base, 9);
        check("t2_no_we", mem_we, 0);

        // N=8 P=3 constant data, force_trigger latched during PRE.
        pulse_start(10'd8, 10'd3, 1'b0, 1'b0, 8'h80);
        base = wr_count;
        send(8'h10, 1'b0);
        force_trigger = 1'b1;
        step();
        force_trigger = 1'b0;
        send(8'h10, 1'b0);
        send(8'h10, 1'b0);
        check("t3_no_trig_in_pre", trigger_addr, 1);
        send(8'h10, 1'b0);
        check("t3_trig_addr", trigger_addr, 3);
        for (int i = 0; i < 3; i++) send(8'h10, 1'b0);
        check("t3_not_done", done, 0);
        send(8'h10, 1'b0);
        check("t3_done", done, 1);
        idle(2);
        check("t3_writes", wr_count - base, 8);

        // N=4 P=9 clamps to 3, external trigger on the sixth sample, R=0.
        pulse_start(10'd4, 10'd9, 1'b1, 1'b0, 8'h00);
        base = wr_count;
        for (int i = 0; i < 5; i++) send(8'h21 + 8'(i), 1'b0);
        check("t4_busy", busy, 1);
        check("t4_not_done", done, 0);
        send(8'h26, 1'b1);
        check("t4_done", done, 1);
        check("t4_busy_end", busy, 0);
        check("t4_we", mem_we, 1);
        check("t4_addr", mem_addr, 1);
        check("t4_data", mem_data, 8'h26);
        check("t4_trig_addr", trigger_addr, 1);
        idle(2);
        check("t4_writes", wr_count - base, 6);

        // start and stop together from DONE: stop wins.
        num_samples = 10'd8;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("t5_ss_busy", busy, 0);
        check("t5_ss_done", done, 0);
        pulse_start(10'd0, 10'd0, 1'b0, 1'b0, 8'h00);
        check("t5_n0_busy", busy, 0);

        // stop mid-WAIT_TRIG, then no further writes.
        pulse_start(10'd8, 10'd0, 1'b0, 1'b0, 8'hf0);
        for (int i = 0; i < 3; i++) send(8'h10, 1'b0);
        check("t5_wait_busy", busy, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t5_stop_busy", busy, 0);
        check("t5_stop_done", done, 0);
        idle(1);
        base = wr_count;
        for (int i = 0; i < 3; i++) begin
            send(8'hf8, 1'b0);
            check("t5_idle_we", mem_we, 0);
        end
        idle(2);
        check("t5_idle_writes", wr_count - base, 0);

        // Asynchronous reset mid-POST.
        pulse_start(10'd8, 10'd0, 1'b1, 1'b0, 8'h00);
        send(8'h55, 1'b0);
        send(8'h55, 1'b0);
        send(8'h55, 1'b1);
        check("t6_trig_addr", trigger_addr, 2);
        send(8'h66, 1'b0);
        check("t6_post_we", mem_we, 1);
        check("t6_post_addr", mem_addr, 3);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_we", mem_we, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_addr", mem_addr, 0);
        check("t6_rst_data", mem_data, 0);
        check("t6_rst_trig_addr", trigger_addr, 0);
        idle(1);
        reset = 1'b0;
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
